// File: rtl/zz_block_arbiter_pkg.sv
// Shared types and constants for the zig_zag block arbiter.
package zz_pkg;

  localparam int BLOCK_COEFFS = 64;
  localparam int COEF_IDX_W   = 6;

  typedef enum logic {
    IDLE = 1'b0,
    FEED = 1'b1
  } zz_arb_state_t;

  typedef logic src_id_t;

  localparam src_id_t SRC_LUMA   = 1'b0;
  localparam src_id_t SRC_CHROMA = 1'b1;

  // Round-robin pick between two requesters; on a tie the one not served last wins.
  function automatic src_id_t pick_winner(input logic v0, input logic v1, input src_id_t last);
    if (v0 && v1) return ~last;
    if (v1)       return SRC_CHROMA;
    return SRC_LUMA;
  endfunction

endpackage

// File: rtl/zz_block_arbiter_if.sv
// Stream bundle between the arbiter, its two sources, the zig_zag engine and the consumer.
interface zz_arb_if #(
  parameter int DW = 24
);
  logic          i_s0_axis_TVALID;
  logic          o_s0_axis_TREADY;
  logic [DW-1:0] i_s0_axis_TDATA;

  logic          i_s1_axis_TVALID;
  logic          o_s1_axis_TREADY;
  logic [DW-1:0] i_s1_axis_TDATA;

  logic          o_zz_axis_TVALID;
  logic          i_zz_axis_TREADY;
  logic [DW-1:0] o_zz_axis_TDATA;
  logic          o_zz_axis_TLAST;

  logic          i_zz_axis_TVALID;
  logic          o_zz_axis_TREADY;
  logic [DW-1:0] i_zz_axis_TDATA;

  logic          o_axis_TVALID;
  logic          i_axis_TREADY;
  logic [DW-1:0] o_axis_TDATA;
  logic          o_axis_TLAST;
  logic          o_axis_TUSER;

  logic          o_err;

  modport slave (
    input  i_s0_axis_TVALID, i_s0_axis_TDATA,
    input  i_s1_axis_TVALID, i_s1_axis_TDATA,
    input  i_zz_axis_TREADY, i_zz_axis_TVALID, i_zz_axis_TDATA, i_axis_TREADY,
    output o_s0_axis_TREADY, o_s1_axis_TREADY,
    output o_zz_axis_TVALID, o_zz_axis_TDATA, o_zz_axis_TLAST, o_zz_axis_TREADY,
    output o_axis_TVALID, o_axis_TDATA, o_axis_TLAST, o_axis_TUSER, o_err
  );

  modport master (
    output i_s0_axis_TVALID, i_s0_axis_TDATA,
    output i_s1_axis_TVALID, i_s1_axis_TDATA,
    output i_zz_axis_TREADY, i_zz_axis_TVALID, i_zz_axis_TDATA, i_axis_TREADY,
    input  o_s0_axis_TREADY, o_s1_axis_TREADY,
    input  o_zz_axis_TVALID, o_zz_axis_TDATA, o_zz_axis_TLAST, o_zz_axis_TREADY,
    input  o_axis_TVALID, o_axis_TDATA, o_axis_TLAST, o_axis_TUSER, o_err
  );
endinterface

// File: rtl/zz_tag_fifo.sv
// Source-ID FIFO tracking blocks granted to zig_zag but not yet returned.
module zz_tag_fifo
  import zz_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    i_clk,
  input  logic    i_aresetn,
  input  logic    i_push,
  input  logic    i_pop,
  input  src_id_t i_din,
  output logic    o_full,
  output logic    o_empty,
  output src_id_t o_head
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  src_id_t       r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_cnt;
  logic          w_do_push, w_do_pop;

  assign o_full    = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  // Head reads as zero when empty so TUSER is clean out of reset.
  assign o_head    = o_empty ? SRC_LUMA : r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge i_clk) begin
    if (!i_aresetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: rtl/zz_block_arbiter.sv
// Grants the zig_zag engine one 64-coefficient block at a time to luma or chroma,
// and tags each returning block with the source that produced it.
module zz_block_arbiter
  import zz_pkg::*;
#(
  parameter int VALUE_WIDTH     = 17,
  parameter int AXIS_DATA_WIDTH = 8*((VALUE_WIDTH-1)/8+1),
  parameter int TAG_DEPTH       = 4
) (
  input logic     i_clk,
  input logic     i_aresetn,
  zz_arb_if.slave bus
);
  localparam logic [COEF_IDX_W-1:0] LAST_IDX = COEF_IDX_W'(BLOCK_COEFFS-1);

  zz_arb_state_t              r_state, w_state_nxt;
  src_id_t                    r_grant, r_last_grant, w_winner, w_head;
  logic [COEF_IDX_W-1:0]      r_in_cnt, r_out_cnt;
  logic                       r_err;
  logic                       w_full, w_empty, w_tag_ok;
  logic                       w_push, w_pop, w_feed_hs, w_out_hs;
  logic                       w_feed_valid, w_s0_ready, w_s1_ready;
  logic [AXIS_DATA_WIDTH-1:0] w_feed_data;

  assign w_winner = pick_winner(bus.i_s0_axis_TVALID, bus.i_s1_axis_TVALID, r_last_grant);
  assign w_push   = (r_state == IDLE) && !w_full &&
                    (bus.i_s0_axis_TVALID || bus.i_s1_axis_TVALID);

  always_comb begin
    w_state_nxt  = r_state;
    w_feed_valid = 1'b0;
    w_feed_data  = '0;
    w_s0_ready   = 1'b0;
    w_s1_ready   = 1'b0;
    w_feed_hs    = 1'b0;
    case (r_state)
      IDLE: if (w_push) w_state_nxt = FEED;
      FEED: begin
        if (r_grant == SRC_CHROMA) begin
          w_feed_valid = bus.i_s1_axis_TVALID;
          w_feed_data  = bus.i_s1_axis_TDATA;
          w_s1_ready   = bus.i_zz_axis_TREADY;
        end else begin
          w_feed_valid = bus.i_s0_axis_TVALID;
          w_feed_data  = bus.i_s0_axis_TDATA;
          w_s0_ready   = bus.i_zz_axis_TREADY;
        end
        w_feed_hs = w_feed_valid && bus.i_zz_axis_TREADY;
        if (w_feed_hs && r_in_cnt == LAST_IDX) w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.o_zz_axis_TVALID = w_feed_valid;
  assign bus.o_zz_axis_TDATA  = w_feed_data;
  assign bus.o_zz_axis_TLAST  = (r_state == FEED) && (r_in_cnt == LAST_IDX);
  assign bus.o_s0_axis_TREADY = w_s0_ready;
  assign bus.o_s1_axis_TREADY = w_s1_ready;

  // Return path is held off entirely until a tag says who owns the data.
  assign w_tag_ok             = !w_empty;
  assign bus.o_axis_TVALID    = bus.i_zz_axis_TVALID && w_tag_ok;
  assign bus.o_zz_axis_TREADY = bus.i_axis_TREADY && w_tag_ok;
  assign bus.o_axis_TDATA     = bus.i_zz_axis_TDATA;
  assign bus.o_axis_TUSER     = w_head;
  assign bus.o_axis_TLAST     = (r_out_cnt == LAST_IDX);
  assign bus.o_err            = r_err;

  assign w_out_hs = bus.o_axis_TVALID && bus.i_axis_TREADY;
  assign w_pop    = w_out_hs && (r_out_cnt == LAST_IDX);

  always_ff @(posedge i_clk) begin
    if (!i_aresetn) begin
      r_state      <= IDLE;
      r_grant      <= SRC_LUMA;
      r_last_grant <= SRC_CHROMA;
      r_in_cnt     <= '0;
      r_out_cnt    <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) begin
        r_grant      <= w_winner;
        r_last_grant <= w_winner;
        r_in_cnt     <= '0;
      end else if (w_feed_hs) begin
        r_in_cnt <= r_in_cnt + 1'b1;
      end
      if (w_out_hs) r_out_cnt <= r_out_cnt + 1'b1;
      if (bus.i_zz_axis_TVALID && w_empty) r_err <= 1'b1;
    end
  end

  zz_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
    .i_clk    (i_clk),
    .i_aresetn(i_aresetn),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_din    (w_winner),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_head   (w_head)
  );
endmodule

// File: tb/tb_zz_block_arbiter.sv
// Scoreboard bench: source drivers, an identity zig_zag stub, feed and output monitors.
module tb_zz_block_arbiter;
  import zz_pkg::*;
  localparam int DW = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  zz_arb_if #(.DW(DW)) bus();

  zz_block_arbiter #(.VALUE_WIDTH(17), .AXIS_DATA_WIDTH(DW), .TAG_DEPTH(4)) dut (
    .i_clk(clk), .i_aresetn(rst_n), .bus(bus)
  );

  typedef struct {
    logic          src;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic [DW-1:0] s0_q[$], s1_q[$], zz_q[$];
  beat_t exp_feed[$], exp_out[$];
  beat_t fe, oe;
  int checks = 0, errors = 0;
  int cyc = 0;
  bit s0_en = 0, s1_en = 0, s1_pause = 0, zz_force = 0;
  bit f0, f1, zin, zout, fsrc;
  int feed_cnt = 0, s1_cnt = 0, blk_start_cyc = 0, last_feed_cyc = 0, pop_cyc = -1;
  int start_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic send_block(input bit src, input int base, input int step);
    logic [DW-1:0] v;
    for (int i = 0; i < 64; i++) begin
      v = DW'(base + step*i);
      if (src) s1_q.push_back(v); else s0_q.push_back(v);
      exp_feed.push_back('{src: src, data: v, last: (i == 63)});
      exp_out.push_back('{src: src, data: v, last: (i == 63)});
    end
  endtask

  // Source 0 driver
  initial begin
    bus.i_s0_axis_TVALID = 1'b0;
    bus.i_s0_axis_TDATA  = '0;
    forever begin
      @(negedge clk);
      f0 = bus.i_s0_axis_TVALID && bus.o_s0_axis_TREADY && rst_n;
      @(posedge clk); #1;
      if (f0 && s0_q.size() > 0) void'(s0_q.pop_front());
      bus.i_s0_axis_TVALID = s0_en && (s0_q.size() > 0);
      bus.i_s0_axis_TDATA  = (s0_q.size() > 0) ? s0_q[0] : '0;
    end
  end

  // Source 1 driver
  initial begin
    bus.i_s1_axis_TVALID = 1'b0;
    bus.i_s1_axis_TDATA  = '0;
    forever begin
      @(negedge clk);
      f1 = bus.i_s1_axis_TVALID && bus.o_s1_axis_TREADY && rst_n;
      @(posedge clk); #1;
      if (f1 && s1_q.size() > 0) void'(s1_q.pop_front());
      bus.i_s1_axis_TVALID = s1_en && !s1_pause && (s1_q.size() > 0);
      bus.i_s1_axis_TDATA  = (s1_q.size() > 0) ? s1_q[0] : '0;
    end
  end

  // zig_zag stub: unbounded identity buffer
  initial begin
    bus.i_zz_axis_TVALID = 1'b0;
    bus.i_zz_axis_TDATA  = '0;
    bus.i_zz_axis_TREADY = 1'b1;
    forever begin
      @(negedge clk);
      zin  = rst_n && bus.o_zz_axis_TVALID && bus.i_zz_axis_TREADY;
      zout = rst_n && bus.i_zz_axis_TVALID && bus.o_zz_axis_TREADY;
      if (zin) zz_q.push_back(bus.o_zz_axis_TDATA);
      @(posedge clk); #1;
      if (zout && zz_q.size() > 0) void'(zz_q.pop_front());
      bus.i_zz_axis_TVALID = zz_force || (zz_q.size() > 0);
      bus.i_zz_axis_TDATA  = (zz_q.size() > 0) ? zz_q[0] : '0;
    end
  end

  // Feed-side monitor
  initial forever begin
    @(negedge clk);
    if (rst_n && bus.o_zz_axis_TVALID && bus.i_zz_axis_TREADY) begin
      fsrc = bus.o_s1_axis_TREADY;
      if (exp_feed.size() == 0) begin
        checks++; errors++;
        $display("FAIL feed_unexpected actual=%0h expected=none", bus.o_zz_axis_TDATA);
      end else begin
        fe = exp_feed.pop_front();
        check("feed_src", 32'(fsrc), 32'(fe.src));
        check("feed_data", 32'(bus.o_zz_axis_TDATA), 32'(fe.data));
        check("feed_last", 32'(bus.o_zz_axis_TLAST), 32'(fe.last));
      end
      if (feed_cnt % 64 == 0) blk_start_cyc = cyc;
      last_feed_cyc = cyc;
      feed_cnt++;
      if (fsrc) s1_cnt++;
    end
  end

  // Output monitor
  initial forever begin
    @(negedge clk);
    if (rst_n && bus.o_axis_TVALID && bus.i_axis_TREADY) begin
      if (exp_out.size() == 0) begin
        checks++; errors++;
        $display("FAIL out_unexpected actual=%0h expected=none", bus.o_axis_TDATA);
      end else begin
        oe = exp_out.pop_front();
        check("out_data", 32'(bus.o_axis_TDATA), 32'(oe.data));
        check("out_user", 32'(bus.o_axis_TUSER), 32'(oe.src));
        check("out_last", 32'(bus.o_axis_TLAST), 32'(oe.last));
        if (oe.last && pop_cyc < 0) pop_cyc = cyc;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    s0_en = 0; s1_en = 0; s1_pause = 0; zz_force = 0;
    s0_q.delete(); s1_q.delete(); zz_q.delete();
    exp_feed.delete(); exp_out.delete();
    bus.i_axis_TREADY = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_s0_ready", 32'(bus.o_s0_axis_TREADY), 0);
    check("rst_s1_ready", 32'(bus.o_s1_axis_TREADY), 0);
    check("rst_zz_valid", 32'(bus.o_zz_axis_TVALID), 0);
    check("rst_zz_last",  32'(bus.o_zz_axis_TLAST), 0);
    check("rst_zz_data",  32'(bus.o_zz_axis_TDATA), 0);
    check("rst_zz_ready", 32'(bus.o_zz_axis_TREADY), 0);
    check("rst_out_valid", 32'(bus.o_axis_TVALID), 0);
    check("rst_out_last", 32'(bus.o_axis_TLAST), 0);
    check("rst_out_user", 32'(bus.o_axis_TUSER), 0);
    check("rst_err",      32'(bus.o_err), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    feed_cnt = 0; s1_cnt = 0; pop_cyc = -1;
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while ((exp_feed.size() > 0 || exp_out.size() > 0) && k < budget) begin
      @(negedge clk); k++;
    end
    check("drain_feed_left", 32'(exp_feed.size()), 0);
    check("drain_out_left",  32'(exp_out.size()), 0);
  endtask

  task automatic wait_feed(input int n, input int budget);
    int k = 0;
    while (feed_cnt < n && k < budget) begin
      @(negedge clk); k++;
    end
    check("wait_feed_reached", 32'(feed_cnt >= n), 1);
  endtask

  initial begin
    bus.i_axis_TREADY = 1'b1;

    // 1: source 0 alone, -1..-64
    do_reset();
    send_block(0, -1, -1);
    start_cyc = cyc;
    s0_en = 1;
    wait_drain(300);
    check("t1_grant_latency", 32'(blk_start_cyc - start_cyc), 2);
    check("t1_block_span", 32'(last_feed_cyc - blk_start_cyc), 63);
    check("t1_err", 32'(bus.o_err), 0);

    // 2: both sources contend, expect strict alternation starting at source 0
    do_reset();
    for (int b = 0; b < 4; b++) begin
      send_block(0, 1, 1);
      send_block(1, 101, 1);
    end
    s0_en = 1; s1_en = 1;
    wait_drain(1500);
    check("t2_feed_total", 32'(feed_cnt), 512);

    // 3: return path stalled, four blocks fill the tag FIFO
    do_reset();
    bus.i_axis_TREADY = 1'b0;
    for (int b = 0; b < 5; b++) send_block(0, 1000 + 64*b, 1);
    s0_en = 1;
    repeat (400) @(negedge clk);
    check("t3_stalled_feed", 32'(feed_cnt), 256);
    pop_cyc = -1;
    @(posedge clk); #2;
    bus.i_axis_TREADY = 1'b1;
    wait_feed(257, 300);
    check("t3_regrant_delay", 32'(blk_start_cyc - pop_cyc), 2);
    wait_drain(800);

    // 4: source 1 pauses mid-block; source 0 must wait
    do_reset();
    send_block(1, 201, 1);
    send_block(0, 301, 1);
    s1_en = 1;
    @(posedge clk); #2;
    s0_en = 1;
    begin
      int k = 0;
      while (s1_cnt < 29 && k < 200) begin @(negedge clk); k++; end
    end
    check("t4_s1_reached", 32'(s1_cnt >= 29), 1);
    s1_pause = 1;
    repeat (10) begin
      @(negedge clk);
      check("t4_s0_ready_held", 32'(bus.o_s0_axis_TREADY), 0);
    end
    s1_pause = 0;
    wait_drain(400);

    // 5: zig_zag returns data with nothing outstanding
    do_reset();
    @(posedge clk); #2;
    zz_force = 1;
    @(negedge clk);
    @(negedge clk);
    check("t5_out_valid", 32'(bus.o_axis_TVALID), 0);
    check("t5_zz_ready", 32'(bus.o_zz_axis_TREADY), 0);
    @(negedge clk);
    check("t5_err_set", 32'(bus.o_err), 1);
    zz_force = 0;
    repeat (3) @(negedge clk);
    check("t5_err_held", 32'(bus.o_err), 1);

    // 6: reset mid-block, then a clean block
    do_reset();
    send_block(0, 1, 1);
    s0_en = 1;
    wait_feed(40, 200);
    do_reset();
    send_block(0, 401, 1);
    s0_en = 1;
    wait_drain(300);
    check("t6_feed_total", 32'(feed_cnt), 64);
    check("t6_err", 32'(bus.o_err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/zz_block_arbiter.md
# zz_block_arbiter

Block-granular arbiter that shares the single zig_zag engine between two coefficient sources in the H.263 encoder: source 0 (luma) and source 1 (chroma). It grants the engine one whole 8x8 block (64 coefficients) at a time, round-robin, and marks the last coefficient of each block with TLAST. It also tags every reordered block coming back from zig_zag with its source ID, so the downstream run-length/VLC stage can route it.

## Interface
- VALUE_WIDTH, 17: signed coefficient width.
- AXIS_DATA_WIDTH, 8*((VALUE_WIDTH-1)/8+1): TDATA width, byte-padded. Value is sign-extended into it.
- TAG_DEPTH, 4: blocks in flight between grant and return; power of 2.
- i_clk  in  1  clock.
- i_aresetn  in  1  reset, synchronous, active-low.
- i_s0_axis_TVALID / o_s0_axis_TREADY / i_s0_axis_TDATA  in/out/in  1/1/AXIS_DATA_WIDTH  source 0 stream.
- i_s1_axis_TVALID / o_s1_axis_TREADY / i_s1_axis_TDATA  in/out/in  1/1/AXIS_DATA_WIDTH  source 1 stream.
- o_zz_axis_TVALID / i_zz_axis_TREADY / o_zz_axis_TDATA / o_zz_axis_TLAST  out/in/out/out  1/1/AXIS_DATA_WIDTH/1  feed to the zig_zag input.
- i_zz_axis_TVALID / o_zz_axis_TREADY / i_zz_axis_TDATA  in/out/in  1/1/AXIS_DATA_WIDTH  return from the zig_zag output.
- o_axis_TVALID / i_axis_TREADY / o_axis_TDATA / o_axis_TLAST / o_axis_TUSER  out/in/out/out/out  1/1/AXIS_DATA_WIDTH/1/1  tagged output. TUSER is the source ID.
- o_err  out  1  sticky error. Set when zig_zag returns data while no tag is outstanding.

## Operation
- FSM states:
  - IDLE: no grant active.
  - FEED: granted source, held in register `grant`, is connected to the zig_zag input.
- IDLE → FEED: taken when the tag FIFO is not full and at least one source has TVALID=1.
  - Winner: the only requesting source. If both request, the source other than `last_grant`.
  - `last_grant` resets to 1, so source 0 wins the first tie.
  - On the transition: `grant` and `last_grant` load the winner, the winner's ID is pushed to the tag FIFO, and `in_cnt` clears to 0.
- FEED datapath (combinational mux):
  - o_zz_axis_TVALID = granted TVALID.
  - o_zz_axis_TDATA = granted TDATA.
  - Granted TREADY = i_zz_axis_TREADY. The non-granted TREADY is 0.
- FEED counting: `in_cnt` (6 bits) increments on each o_zz handshake.
  - o_zz_axis_TLAST = 1 while `in_cnt`==63.
  - A handshake at `in_cnt`==63 returns the FSM to IDLE.
- IDLE outputs: all source TREADY = 0 and o_zz_axis_TVALID = 0.
- A source that drops TVALID mid-block keeps the grant. There is no timeout and no preemption.
- Return path:
  - `tag_ok` = tag FIFO not empty.
  - o_axis_TVALID = i_zz_axis_TVALID & `tag_ok`.
  - o_zz_axis_TREADY = i_axis_TREADY & `tag_ok`.
  - o_axis_TDATA = i_zz_axis_TDATA.
  - o_axis_TUSER = head of the tag FIFO.
- Return counting: `out_cnt` (6 bits) increments on each o_axis handshake.
  - o_axis_TLAST = 1 while `out_cnt`==63.
  - The handshake at `out_cnt`==63 pops the tag FIFO and wraps `out_cnt` to 0.
- Tag FIFO push and pop in the same cycle are both honoured; occupancy is unchanged. A push is never attempted while the FIFO is full.
- o_err sets on any cycle with i_zz_axis_TVALID=1 and the tag FIFO empty. It clears only on reset.

## Timing
- Reset (i_aresetn=0 at a rising edge), applicable mid-operation:
  - state = IDLE; `in_cnt` = `out_cnt` = 0; tag FIFO emptied; `last_grant` = 1; o_err = 0.
  - All TVALID, TREADY and TLAST outputs are 0.
  - o_axis_TUSER = 0 and o_zz_axis_TDATA = 0.
- Data latency through the block in both directions: 0 cycles (combinational).
- Grant overhead: 1 IDLE cycle per block.
  - Back-to-back blocks therefore take at least 65 cycles each on the feed side.
  - The first coefficient of a block can hand off in the cycle after the grant.
- Flow control:
  - A full tag FIFO (TAG_DEPTH blocks outstanding) stalls the next grant until a pop.
  - A pop and the IDLE→FEED grant may occur in the same cycle; the grant sees the pre-pop full flag and waits one cycle.
- All AXI-Stream rules apply:
  - TDATA, TLAST and TUSER stay stable while TVALID=1 and TREADY=0.
  - TVALID does not depend on TREADY, except through the source pass-through.

## Structure
- Package `zz_pkg`:
  - BLOCK_COEFFS = 64; COEF_IDX_W = 6.
  - typedef enum `zz_arb_state_t` {IDLE, FEED}.
  - typedef `src_id_t` (1 bit); constants SRC_LUMA = 0 and SRC_CHROMA = 1.
- Sub-module: `zz_tag_fifo` — synchronous FIFO, TAG_DEPTH × `src_id_t`.
  - Ports: push, pop, full, empty, head.
  - Reset: synchronous, active-low.
- Top level: FSM, the two counters, muxes and the error flag.

## Test plan
- Source 0 alone sends 64 values (-1..-64); zig_zag stub returns them → o_axis carries 64 beats, TUSER=0, TLAST only on beat 64, exactly one grant cycle, o_err=0.
- Both sources valid continuously, 4 blocks each (s0 values 1..64, s1 values 101..164) → grants alternate 0,1,0,1…; output TUSER sequence is 0,1,0,1,…; each feed-side TLAST is on coefficient 64.
- Stall the return path (i_axis_TREADY=0) → after 4 granted blocks no further grant; release TREADY → grant resumes on the cycle after the first pop plus one.
- Source 1 deasserts TVALID for 10 cycles at coefficient 30 → s0_TREADY stays 0 throughout; block completes with 64 beats; no grant switch.
- Assert i_zz_axis_TVALID with no block outstanding → o_axis_TVALID=0, o_zz_axis_TREADY=0, o_err=1 next cycle and held.
- Reset at coefficient 40 of a block → next cycle all outputs at their reset values; a fresh block then completes normally with TLAST on beat 64.
